// File: rtl/decrypt_pkg.sv
// Shared types and constant-derivation helpers for the LWE decrypt datapath.
package decrypt_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } state_t;

    // Bit width of the ciphertext modulus q (q is a power of two).
    function automatic int calc_qb(input int q);
        return $clog2(q);
    endfunction

    // Bit width of the plaintext modulus p (p is a power of two).
    function automatic int calc_pb(input int p);
        return $clog2(p);
    endfunction

    // Number of beats needed to stream n elements over par lanes.
    function automatic int calc_beats(input int n, input int par);
        return (n + par - 1) / par;
    endfunction

    // Rounding offset q/(2p) added before the decode shift.
    function automatic int calc_half(input int q, input int p);
        return q / (2 * p);
    endfunction

    // Beat counter width; at least one bit even for a single-beat ciphertext.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/decrypt_dot.sv
// Combinational lane-masked dot product of one beat, reduced mod 2^QB.
// Lanes whose element index falls past DIMENSION contribute nothing, so the
// padding lanes of the final beat may carry arbitrary data.
module decrypt_dot
    import decrypt_pkg::*;
#(
    parameter int PARALLEL  = 2,
    parameter int QB        = 10,
    parameter int CW        = 32,
    parameter int DIMENSION = 3,
    parameter int BASE_W    = 2
) (
    input  logic [PARALLEL*CW-1:0] a,
    input  logic [PARALLEL*CW-1:0] sk,
    input  logic [BASE_W-1:0]      base,
    output logic [QB-1:0]          dot
);

    // Element bits above QB never influence a mod-q result.
    logic [PARALLEL-1:0] unused_hi;

    for (genvar g = 0; g < PARALLEL; g++) begin : g_unused
        assign unused_hi[g] = ^{a[g*CW+QB +: CW-QB], sk[g*CW+QB +: CW-QB]};
    end

    // Sum of per-lane products; every add and multiply wraps at QB bits.
    always_comb begin
        dot = '0;
        for (int k = 0; k < PARALLEL; k++) begin
            if ((32'(base) + 32'(k)) < 32'(DIMENSION)) begin
                dot = dot + a[k*CW +: QB] * sk[k*CW +: QB];
            end
        end
    end

endmodule

// File: rtl/decrypt.sv
// LWE decrypt: accumulates <a,s> mod q over PARALLEL-lane beats, then decodes
// round((b - <a,s>) * p / q) mod p and offers it on a valid/ready output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// ACCUM  | accepting beats, acc holds the running partial dot product
// DECODE | last beat taken, b and final acc captured, plaintext computed
// OUT    | plaintext held with pt_valid until the consumer takes it
module decrypt
    import decrypt_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = 64,
    parameter int PLAINTEXT_WIDTH    = 6,
    parameter int CIPHERTEXT_MODULUS = 1024,
    parameter int CIPHERTEXT_WIDTH   = 32,
    parameter int DIMENSION          = 3,
    parameter int DIM_WIDTH          = 2,
    parameter int PARALLEL           = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] a_in,
    input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] sk_in,
    input  logic [CIPHERTEXT_WIDTH-1:0]          b_in,
    output logic                                 pt_valid,
    input  logic                                 pt_ready,
    output logic [PLAINTEXT_WIDTH-1:0]           plaintext
);

    localparam int QB    = calc_qb(CIPHERTEXT_MODULUS);
    localparam int PB    = calc_pb(PLAINTEXT_MODULUS);
    localparam int BEATS = calc_beats(DIMENSION, PARALLEL);
    localparam int HALF  = calc_half(CIPHERTEXT_MODULUS, PLAINTEXT_MODULUS);
    localparam int CNT_W = cnt_width(BEATS);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [QB-1:0]    HALF_Q    = QB'(HALF);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [QB-1:0]        acc;
    logic [QB-1:0]        b_reg;
    logic [QB-1:0]        dot;
    logic [QB-1:0]        diff;
    logic [QB-1:0]        rounded;
    logic [DIM_WIDTH-1:0] base;
    logic                 beat_fire;
    logic                 last_beat;
    logic                 unused_b;

    assign unused_b = ^b_in[CIPHERTEXT_WIDTH-1:QB];

    assign base = DIM_WIDTH'(32'(beat_cnt) * 32'(PARALLEL));

    decrypt_dot #(
        .PARALLEL  (PARALLEL),
        .QB        (QB),
        .CW        (CIPHERTEXT_WIDTH),
        .DIMENSION (DIMENSION),
        .BASE_W    (DIM_WIDTH)
    ) u_dot (
        .a    (a_in),
        .sk   (sk_in),
        .base (base),
        .dot  (dot)
    );

    // Ready is decoded from the registered state only; reset forces it low
    // so nothing is taken while the block is being cleared.
    assign in_ready  = (state == ACCUM) && !rst;
    assign beat_fire = in_valid && in_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);

    // Rounded decode: adding q/(2p) before dropping the low QB-PB bits
    // rounds to nearest, with wrap at q folding near-q diffs back to 0.
    assign diff    = b_reg - acc;
    assign rounded = diff + HALF_Q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (in_valid && last_beat) next_state = DECODE;
            DECODE:  next_state = OUT;
            OUT:     if (pt_ready) next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Beat counting, accumulation, capture of b, and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            acc       <= '0;
            b_reg     <= '0;
            pt_valid  <= 1'b0;
            plaintext <= '0;
        end else begin
            if (beat_fire) begin
                acc <= acc + dot;
                if (last_beat) begin
                    beat_cnt <= '0;
                    b_reg    <= b_in[QB-1:0];
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (state == DECODE) begin
                plaintext <= rounded[QB-1 -: PB];
                pt_valid  <= 1'b1;
            end
            if (state == OUT && pt_ready) begin
                pt_valid <= 1'b0;
                acc      <= '0;
            end
        end
    end

endmodule
